// File: rtl/ibex_alu_bist_pkg.sv
// Shared types and constants for the Ibex ALU online BIST sequencer.
// Operator values follow the ibex_pkg alu_op_e encoding.
package ibex_alu_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_CHECK,
      ST_DONE
   } bist_state_e;

   localparam int unsigned NUM_OPS = 10;

   localparam logic [6:0] ALU_ADD  = 7'd0;
   localparam logic [6:0] ALU_SUB  = 7'd1;
   localparam logic [6:0] ALU_XOR  = 7'd2;
   localparam logic [6:0] ALU_OR   = 7'd3;
   localparam logic [6:0] ALU_AND  = 7'd4;
   localparam logic [6:0] ALU_SRA  = 7'd8;
   localparam logic [6:0] ALU_SRL  = 7'd9;
   localparam logic [6:0] ALU_SLL  = 7'd10;
   localparam logic [6:0] ALU_SLT  = 7'd43;
   localparam logic [6:0] ALU_SLTU = 7'd44;

   // Entry 0 is the rightmost element.
   localparam logic [NUM_OPS-1:0][6:0] OP_TABLE = {
      ALU_SLTU, ALU_SLT, ALU_SRA, ALU_SRL, ALU_SLL,
      ALU_AND,  ALU_OR,  ALU_XOR, ALU_SUB, ALU_ADD
   };

   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   // MISR feedback from bits 31, 21, 1, 0
   localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/ibex_bist_misr.sv
// 32-bit multiple-input signature register with synchronous clear and enable.
module ibex_bist_misr
   import ibex_alu_bist_pkg::*;
#(
   parameter logic [31:0] TAPS = MISR_TAPS
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [31:0] i_data,
   output logic [31:0] o_sig
);

   logic [31:0] r_sig;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sig <= '0;
      end else if (i_clr) begin
         r_sig <= '0;
      end else if (i_en) begin
         r_sig <= {r_sig[30:0], ^(r_sig & TAPS)} ^ i_data;
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/ibex_alu_bist_ctrl.sv
// Online BIST sequencer for the Ibex ALU: LFSR vectors, MISR compaction, core preemption.
// Optional macro IBEX_ALU_BIST_FAULT_INJ_EN adds fault_inj_i to flip result bit 0.
module ibex_alu_bist_ctrl
   import ibex_alu_bist_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [31:0] SEED_A      = 32'h1D87_2B41,
   parameter logic [31:0] SEED_B      = 32'hA5A5_5A5A
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        core_req_i,
`ifdef IBEX_ALU_BIST_FAULT_INJ_EN
   input  logic        fault_inj_i,
`endif
   input  logic [31:0] expected_sig_i,
   input  logic [31:0] alu_result_i,
   input  logic        alu_cmp_result_i,
   output logic        bist_sel_o,
   output logic [6:0]  alu_operator_o,
   output logic [31:0] alu_operand_a_o,
   output logic [31:0] alu_operand_b_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic        fail_o,
   output logic [31:0] signature_o,
   output logic [15:0] vec_cnt_o
);

   if (NUM_VECTORS < 2 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
      $error("NUM_VECTORS must be within 2..65535");
   end
   if (SEED_A == 32'h0) begin : g_bad_seed
      $error("SEED_A must be nonzero");
   end

   bist_state_e r_state, w_next;
   logic [31:0] r_lfsr;
   logic [3:0]  r_op_idx;
   logic [15:0] r_vec_cnt;
   logic        r_pass, r_fail;
   logic        w_start, w_capture, w_last;
   logic [31:0] w_result, w_misr_data, w_sig;

   assign w_start   = start_i & ~core_req_i & ((r_state == ST_IDLE) | (r_state == ST_DONE));
   assign w_capture = (r_state == ST_RUN) & ~core_req_i;
   assign w_last    = (r_vec_cnt == 16'(NUM_VECTORS - 1));

`ifdef IBEX_ALU_BIST_FAULT_INJ_EN
   assign w_result = alu_result_i ^ {31'b0, fault_inj_i};
`else
   assign w_result = alu_result_i;
`endif
   assign w_misr_data = w_result ^ {31'b0, alu_cmp_result_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (w_start) w_next = ST_RUN;
         ST_RUN: begin
            if (core_req_i)  w_next = ST_PAUSE;
            else if (w_last) w_next = ST_CHECK;
         end
         ST_PAUSE: if (!core_req_i) w_next = ST_RUN;
         ST_CHECK: w_next = ST_DONE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // A preempted RUN cycle releases the mux immediately; its vector is replayed later.
   always_comb begin
      bist_sel_o      = 1'b0;
      alu_operator_o  = '0;
      alu_operand_a_o = '0;
      alu_operand_b_o = '0;
      busy_o          = 1'b0;
      done_o          = 1'b0;
      case (r_state)
         ST_RUN: begin
            busy_o = 1'b1;
            if (!core_req_i) begin
               bist_sel_o      = 1'b1;
               alu_operator_o  = OP_TABLE[r_op_idx];
               alu_operand_a_o = r_lfsr;
               alu_operand_b_o = {r_lfsr[15:0], r_lfsr[31:16]} ^ SEED_B;
            end
         end
         ST_PAUSE, ST_CHECK: busy_o = 1'b1;
         ST_DONE:            done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_lfsr    <= SEED_A;
         r_op_idx  <= '0;
         r_vec_cnt <= '0;
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
      end else if (w_start) begin
         r_lfsr    <= SEED_A;
         r_op_idx  <= '0;
         r_vec_cnt <= '0;
         r_pass    <= 1'b0;
         r_fail    <= 1'b0;
      end else if (w_capture) begin
         r_lfsr    <= lfsr_next(r_lfsr);
         r_op_idx  <= (r_op_idx == 4'(NUM_OPS - 1)) ? '0 : r_op_idx + 4'd1;
         r_vec_cnt <= r_vec_cnt + 16'd1;
      end else if (r_state == ST_CHECK) begin
         r_pass <= (w_sig == expected_sig_i);
         r_fail <= (w_sig != expected_sig_i);
      end
   end

   ibex_bist_misr #(
      .TAPS (MISR_TAPS)
   ) u_misr (
      .i_clk  (clk_i),
      .i_rst  (rst_i),
      .i_clr  (w_start),
      .i_en   (w_capture),
      .i_data (w_misr_data),
      .o_sig  (w_sig)
   );

   assign pass_o      = r_pass;
   assign fail_o      = r_fail;
   assign signature_o = w_sig;
   assign vec_cnt_o   = r_vec_cnt;

endmodule

// File: tb/tb_ibex_alu_bist_ctrl.sv
// Self-checking bench for ibex_alu_bist_ctrl with a behavioural ALU and signature model.
// Define IBEX_ALU_BIST_FAULT_INJ_EN to also exercise fault injection.
module tb_ibex_alu_bist_ctrl;

   localparam int unsigned NV     = 16;
   localparam logic [31:0] SEED_A = 32'h1D87_2B41;
   localparam logic [31:0] SEED_B = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        rst, start, core_req, cmp_res;
   logic [31:0] exp_sig, alu_res;
   logic        bist_sel, busy, done, pass, fail;
   logic [6:0]  alu_op;
   logic [31:0] op_a, op_b, sig;
   logic [15:0] vec_cnt;
`ifdef IBEX_ALU_BIST_FAULT_INJ_EN
   logic        fault_inj;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [6:0] OPS [10] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd10, 7'd9, 7'd8, 7'd43, 7'd44};

   always #5 clk = ~clk;

   ibex_alu_bist_ctrl #(
      .NUM_VECTORS (NV),
      .SEED_A      (SEED_A),
      .SEED_B      (SEED_B)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .core_req_i       (core_req),
`ifdef IBEX_ALU_BIST_FAULT_INJ_EN
      .fault_inj_i      (fault_inj),
`endif
      .expected_sig_i   (exp_sig),
      .alu_result_i     (alu_res),
      .alu_cmp_result_i (cmp_res),
      .bist_sel_o       (bist_sel),
      .alu_operator_o   (alu_op),
      .alu_operand_a_o  (op_a),
      .alu_operand_b_o  (op_b),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .fail_o           (fail),
      .signature_o      (sig),
      .vec_cnt_o        (vec_cnt)
   );

   // Behavioural ALU: {comparison_result, result}
   function automatic logic [32:0] alu_ref(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        c;
      r = '0;
      c = 1'b0;
      case (op)
         7'd0:  r = a + b;
         7'd1:  r = a - b;
         7'd2:  r = a ^ b;
         7'd3:  r = a | b;
         7'd4:  r = a & b;
         7'd10: r = a << b[4:0];
         7'd9:  r = a >> b[4:0];
         7'd8:  r = 32'($signed(a) >>> b[4:0]);
         7'd43: begin c = ($signed(a) < $signed(b)); r = {31'b0, c}; end
         7'd44: begin c = (a < b); r = {31'b0, c}; end
         default: ;
      endcase
      return {c, r};
   endfunction

   always_comb {cmp_res, alu_res} = alu_ref(alu_op, op_a, op_b);

   // Reference signature of an NV-vector run; fault_vec flips result bit 0 of that vector.
   function automatic logic [31:0] model_sig(input int fault_vec);
      logic [31:0] l, m, a, b, r;
      logic        c;
      l = SEED_A;
      m = '0;
      for (int v = 0; v < int'(NV); v++) begin
         a = l;
         b = {l[15:0], l[31:16]} ^ SEED_B;
         {c, r} = alu_ref(OPS[v % 10], a, b);
         if (v == fault_vec) r[0] = ~r[0];
         m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ r ^ {31'b0, c};
         l = l[0] ? ({1'b0, l[31:1]} ^ 32'h8020_0003) : {1'b0, l[31:1]};
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs until busy drops; optionally checks the first 12 operators.
   task automatic run_to_done(input bit chk_ops, output int busy_n);
      int sel_n = 0;
      int k = 0;
      busy_n = 0;
      while (busy && k < 200) begin
         if (chk_ops && bist_sel && sel_n < 12) chk("op_seq", {25'b0, alu_op}, {25'b0, OPS[sel_n % 10]});
         if (bist_sel) sel_n++;
         busy_n++;
         k++;
         tick();
      end
      chk("done_reached", {31'b0, done}, 32'd1);
   endtask

   task automatic wait_vec(input int n);
      int k = 0;
      while (vec_cnt != 16'(n) && k < 100) begin
         k++;
         tick();
      end
      chk("reach_vec", {16'b0, vec_cnt}, n);
   endtask

   logic [31:0] golden, sv_a, sv_b;
   logic [6:0]  sv_op;
   int          busy_n;

   initial begin
      #200000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; core_req = 1'b0; exp_sig = '0;
`ifdef IBEX_ALU_BIST_FAULT_INJ_EN
      fault_inj = 1'b0;
`endif
      golden = model_sig(-1);
      repeat (2) tick();
      chk("rst_bist_sel", {31'b0, bist_sel}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_pass_fail", {30'b0, pass, fail}, 32'd0);
      chk("rst_sig", sig, 32'd0);
      chk("rst_vec_cnt", {16'b0, vec_cnt}, 32'd0);
      chk("rst_op_a", op_a, 32'd0);
      rst = 1'b0;
      tick();

      // Uninterrupted run, matching signature
      exp_sig = golden;
      pulse_start();
      chk("first_op_a", op_a, SEED_A);
      chk("first_op_b", op_b, {SEED_A[15:0], SEED_A[31:16]} ^ SEED_B);
      run_to_done(1'b1, busy_n);
      chk("busy_cycles", busy_n, 32'd17);
      chk("vec_cnt_final", {16'b0, vec_cnt}, NV);
      chk("sig_final", sig, golden);
      chk("pass_run1", {30'b0, pass, fail}, 32'b10);
      chk("bist_sel_done", {31'b0, bist_sel}, 32'd0);
      repeat (3) tick();
      chk("done_sticky", {30'b0, done, pass}, 32'b11);

      // Start with core request in DONE is dropped
      start = 1'b1; core_req = 1'b1;
      tick();
      start = 1'b0; core_req = 1'b0;
      tick();
      chk("start_ignored", {30'b0, done, busy}, 32'b10);

      // Mismatching golden value
      exp_sig = golden ^ 32'h1;
      pulse_start();
      chk("start_clears", {29'b0, done, pass, fail}, 32'd0);
      run_to_done(1'b0, busy_n);
      chk("fail_run2", {30'b0, pass, fail}, 32'b01);
      chk("sig_run2", sig, golden);

      exp_sig = golden ^ (32'h1 << $urandom_range(31, 0));
      pulse_start();
      run_to_done(1'b0, busy_n);
      chk("fail_rand_bit", {30'b0, pass, fail}, 32'b01);

      // Preemption at vector 5 for three cycles
      exp_sig = golden;
      pulse_start();
      wait_vec(5);
      sv_a = op_a; sv_b = op_b; sv_op = alu_op;
      core_req = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("pause_bist_sel", {31'b0, bist_sel}, 32'd0);
         chk("pause_vec_cnt", {16'b0, vec_cnt}, 32'd5);
         tick();
      end
      core_req = 1'b0;
      tick();
      chk("resume_sel", {31'b0, bist_sel}, 32'd1);
      chk("resume_op_a", op_a, sv_a);
      chk("resume_op_b", op_b, sv_b);
      chk("resume_op", {25'b0, alu_op}, {25'b0, sv_op});
      run_to_done(1'b0, busy_n);
      chk("sig_preempt", sig, golden);
      chk("pass_preempt", {30'b0, pass, fail}, 32'b10);

      // Asynchronous reset at vector 7
      pulse_start();
      wait_vec(7);
      #2 rst = 1'b1;
      #1;
      chk("arst_outputs", {27'b0, bist_sel, busy, done, pass, fail}, 32'd0);
      chk("arst_sig", sig, 32'd0);
      chk("arst_op_a", op_a, 32'd0);
      #1 rst = 1'b0;
      tick();
      pulse_start();
      chk("rerun_op_a", op_a, SEED_A);
      run_to_done(1'b0, busy_n);
      chk("rerun_busy", busy_n, 32'd17);
      chk("rerun_sig", sig, golden);

      // Random core requests and stray start pulses
      for (int r = 0; r < 4; r++) begin
         int k = 0;
         exp_sig = golden;
         pulse_start();
         while (!done && k < 400) begin
            core_req = ($urandom_range(2, 0) == 0);
            start    = ($urandom_range(4, 0) == 0);
            k++;
            tick();
         end
         core_req = 1'b0;
         start    = 1'b0;
         chk("rand_done", {31'b0, done}, 32'd1);
         chk("rand_sig", sig, golden);
         chk("rand_vec_cnt", {16'b0, vec_cnt}, NV);
         chk("rand_pass", {30'b0, pass, fail}, 32'b10);
         tick();
      end

`ifdef IBEX_ALU_BIST_FAULT_INJ_EN
      exp_sig = golden;
      pulse_start();
      wait_vec(3);
      fault_inj = 1'b1;
      tick();
      fault_inj = 1'b0;
      run_to_done(1'b0, busy_n);
      chk("finj_fail", {30'b0, pass, fail}, 32'b01);
      chk("finj_sig", sig, model_sig(3));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
